// File: rtl/sub32_seq_pkg.sv
// Shared types and constants for the sequential half-width subtractor.
package sub_pkg;

    // Default operand width for sub32_seq and its bus interface.
    localparam int SUB_WIDTH_DEF = 32;

    // Operation sequencing: capture operands, low half, high half, hold result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } sub_state_e;

endpackage

// File: rtl/sub32_seq_if.sv
// Valid/ready operand and result bus for sub32_seq.
// The zero/ovf flag signals exist only when SUB_FLAGS_EN is defined.
interface sub32_seq_if
    import sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEF
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
`ifdef SUB_FLAGS_EN
    logic             zero;
    logic             ovf;
`endif

    // Producer of operands / consumer of results.
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow
`ifdef SUB_FLAGS_EN
        , input zero, ovf
`endif
    );

    // The subtractor itself.
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow
`ifdef SUB_FLAGS_EN
        , output zero, ovf
`endif
    );

endinterface

// File: rtl/sub32_seq_half_slice.sv
// Half-width subtract slice: s = x + ~y + cin, carry out on cout.
// A carry out of 1 means "no borrow" from this slice.
module sub_half_slice #(
    parameter int HALF = 16
) (
    input  logic [HALF-1:0] x,
    input  logic [HALF-1:0] y,
    input  logic            cin,
    output logic [HALF-1:0] s,
    output logic            cout
);

    // One-bit-wider add so the carry out falls out of the top bit.
    assign {cout, s} = {1'b0, x} + {1'b0, ~y} + {{HALF{1'b0}}, cin};

endmodule

// File: rtl/sub32_seq.sv
// Multi-cycle subtractor: diff = a - b using one half-width slice over two
// cycles (low half, then high half), with borrow = (a < b) unsigned.
// Optional macro SUB_FLAGS_EN adds registered zero and signed-overflow flags.
module sub32_seq
    import sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEF
) (
    input  logic          clk,
    input  logic          rst,
    sub32_seq_if.slave    bus
);

    localparam int HALF = WIDTH / 2;

    sub_state_e       state_q;
    sub_state_e       state_d;

    logic [WIDTH-1:0] a_p0;
    logic [WIDTH-1:0] b_p0;
    logic [HALF-1:0]  lo_p1;
    logic             c_lo_p1;

    logic [WIDTH-1:0] diff_p2;
    logic             borrow_p2;
`ifdef SUB_FLAGS_EN
    logic             zero_p2;
    logic             ovf_p2;
`endif

    logic [HALF-1:0]  sl_x;
    logic [HALF-1:0]  sl_y;
    logic             sl_cin;
    logic [HALF-1:0]  sl_s;
    logic             sl_cout;

    logic             in_fire;
    logic             out_fire;

`ifdef SUB_FLAGS_EN
    // Signed overflow: operands of different sign and result sign differs from a.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                        input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction
`endif

    assign in_fire  = (state_q == IDLE) && bus.in_valid;
    assign out_fire = (state_q == DONE) && bus.out_ready;

    // Next-state sequencing; one pass through LOW and HIGH per operation.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_fire)  state_d = LOW;
            LOW:                   state_d = HIGH;
            HIGH:                  state_d = DONE;
            DONE:    if (out_fire) state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    // Route the operand halves and carry-in into the shared slice.
    always_comb begin
        sl_x   = a_p0[HALF-1:0];
        sl_y   = b_p0[HALF-1:0];
        sl_cin = 1'b1;
        if (state_q == HIGH) begin
            sl_x   = a_p0[WIDTH-1:HALF];
            sl_y   = b_p0[WIDTH-1:HALF];
            sl_cin = c_lo_p1;
        end
    end

    sub_half_slice #(
        .HALF (HALF)
    ) u_slice (
        .x    (sl_x),
        .y    (sl_y),
        .cin  (sl_cin),
        .s    (sl_s),
        .cout (sl_cout)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Stage p0: operand capture on input handshake.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            a_p0 <= bus.a;
            b_p0 <= bus.b;
        end
    end

    // Stage p1: low-half difference and the carry handed to the high half.
    always_ff @(posedge clk) begin
        if (state_q == LOW) begin
            lo_p1   <= sl_s;
            c_lo_p1 <= sl_cout;
        end
    end

    // Stage p2: assemble the full result; held until the next operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            diff_p2   <= '0;
            borrow_p2 <= 1'b0;
        end else if (state_q == HIGH) begin
            diff_p2   <= {sl_s, lo_p1};
            borrow_p2 <= ~sl_cout;
        end
    end

`ifdef SUB_FLAGS_EN
    // Flags registered alongside the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_p2 <= 1'b0;
            ovf_p2  <= 1'b0;
        end else if (state_q == HIGH) begin
            zero_p2 <= ({sl_s, lo_p1} == '0);
            ovf_p2  <= signed_ovf(a_p0[WIDTH-1], b_p0[WIDTH-1], sl_s[HALF-1]);
        end
    end

    assign bus.zero = zero_p2;
    assign bus.ovf  = ovf_p2;
`endif

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.diff      = diff_p2;
    assign bus.borrow    = borrow_p2;

endmodule

// File: tb/tb_sub32_seq.sv
// Directed and randomized bench for sub32_seq (SUB_FLAGS_EN enables flag tests).
module tb_sub32_seq;
    import sub_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sub32_seq_if #(.WIDTH(W)) bus ();

    sub32_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands and wait (bounded) for them to be taken.
    task automatic accept_op(input string tag, input logic [W-1:0] a,
                             input logic [W-1:0] b);
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 20 && !bus.in_ready; i++) tick();
        check_val({tag, "_in_ready"}, bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 10 && !bus.out_valid; i++) tick();
        check_val({tag, "_out_valid"}, bus.out_valid, 1);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_d,
                          input logic exp_b, input int stall);
        accept_op(tag, a, b);
        wait_done(tag);
        check_val({tag, "_diff"}, bus.diff, exp_d);
        check_val({tag, "_borrow"}, bus.borrow, exp_b);
        for (int i = 0; i < stall; i++) begin
            tick();
            check_val({tag, "_stall_valid"}, bus.out_valid, 1);
            check_val({tag, "_stall_diff"}, bus.diff, exp_d);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check_val({tag, "_drop"}, bus.out_valid, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra, rb;
        int first, second, stall;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_val("rst_in_ready", bus.in_ready, 1);
        check_val("rst_out_valid", bus.out_valid, 0);
        check_val("rst_diff", bus.diff, 0);
        check_val("rst_borrow", bus.borrow, 0);

        // 1: 5 - 3 with latency: LOW, HIGH, then DONE after the accept edge
        bus.a = 32'd5; bus.b = 32'd3; bus.in_valid = 1'b1;
        check_val("t1_in_ready", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        check_val("t1_lat_low_valid", bus.out_valid, 0);
        check_val("t1_lat_low_in_ready", bus.in_ready, 0);
        tick();
        check_val("t1_lat_high_valid", bus.out_valid, 0);
        tick();
        check_val("t1_lat_done_valid", bus.out_valid, 1);
        check_val("t1_diff", bus.diff, 32'h0000_0002);
        check_val("t1_borrow", bus.borrow, 0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check_val("t1_drop", bus.out_valid, 0);
        check_val("t1_diff_kept", bus.diff, 32'h0000_0002);
        check_val("t1_idle_in_ready", bus.in_ready, 1);

        // 2: wrap-around
        run_op("t2", 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 0);

        // 4: backpressure, with operands offered while busy
        accept_op("t4", 32'h1234_5678, 32'h1234_5678);
        wait_done("t4");
        bus.a = 32'h0000_0001; bus.b = 32'h0000_0002; bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("t4_hold_valid", bus.out_valid, 1);
            check_val("t4_hold_diff", bus.diff, 32'h0);
            check_val("t4_hold_borrow", bus.borrow, 0);
            check_val("t4_hold_in_ready", bus.in_ready, 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check_val("t4_drop", bus.out_valid, 0);
        tick();
        tick();
        tick();
        check_val("t4_no_extra_op", bus.out_valid, 0);

        // 3: borrow across the half boundary
        run_op("t3", 32'h0001_0000, 32'h0000_0001, 32'h0000_FFFF, 1'b0, 2);

        // 5: reset while in HIGH discards the operation
        accept_op("t5", 32'hDEAD_BEEF, 32'h0000_0001);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("t5_rst_valid", bus.out_valid, 0);
        check_val("t5_rst_diff", bus.diff, 0);
        check_val("t5_rst_in_ready", bus.in_ready, 1);
        check_val("t5_rst_borrow", bus.borrow, 0);
        tick();
        tick();
        tick();
        check_val("t5_no_result", bus.out_valid, 0);
        run_op("t5_new", 32'd9, 32'd4, 32'd5, 1'b0, 0);

`ifdef SUB_FLAGS_EN
        // 6: flags
        run_op("t6a", 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 0);
        check_val("t6a_ovf", bus.ovf, 1);
        check_val("t6a_zero", bus.zero, 0);
        run_op("t6b", 32'd7, 32'd7, 32'd0, 1'b0, 0);
        check_val("t6b_zero", bus.zero, 1);
        check_val("t6b_ovf", bus.ovf, 0);
`endif

        // Back-to-back acceptance interval with out_ready held high
        bus.a = 32'd20; bus.b = 32'd7;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        first = -1; second = -1;
        for (int cyc = 0; cyc < 16; cyc++) begin
            if (bus.in_ready) begin
                if (first < 0) first = cyc;
                else if (second < 0) second = cyc;
            end
            tick();
        end
        check_val("interval", second - first, 4);
        check_val("interval_diff", bus.diff, 32'd13);
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        for (int i = 0; i < 6 && !bus.in_ready; i++) tick();
        if (bus.out_valid) begin
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
        end

        // Random ops against a - b with random result stalls
        for (int n = 0; n < 10000; n++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: ra = '0;
                1: rb = '1;
                2: rb = ra;
                3: ra = {16'h0000, ra[15:0]};
                default: ;
            endcase
            stall = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
            run_op("rand", ra, rb, ra - rb, (ra < rb), stall);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
